// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared state encoding and default geometry for the serial adder/subtractor
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

endpackage

// File: rtl/serial_addsub_chunk_adder.sv
// rtl/serial_addsub_chunk_adder.sv - combinational CHUNK-bit ripple adder exposing the carry into its MSB
module chunk_adder
    import serial_addsub_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout     = c[CHUNK];
        c_msb_in = c[CHUNK-1];
    end

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - multi-cycle add/subtract, CHUNK bits per cycle, valid/ready on both sides
// Optional signed saturation of the result is enabled by defining SERIAL_ADDSUB_SAT_EN.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             cf,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N) + 1;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sub_q;

    int                 idx;
    logic [CHUNK-1:0]   x_chunk;
    logic [CHUNK-1:0]   y_chunk;
    logic [CHUNK-1:0]   sum_c;
    logic               cout_c;
    logic               c_msb;
    logic               ovf_n;
    logic [WIDTH-1:0]   s_wrap;
    logic [WIDTH-1:0]   s_fin;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .x        (x_chunk),
        .y        (y_chunk),
        .cin      (carry),
        .sum      (sum_c),
        .cout     (cout_c),
        .c_msb_in (c_msb)
    );

    // cnt parks at N after the last chunk; clamp so the selects stay in range.
    always_comb begin
        idx     = (cnt < CW'(N)) ? int'(cnt) * CHUNK : 0;
        x_chunk = a_q[idx +: CHUNK];
        y_chunk = b_q[idx +: CHUNK];
        s_wrap  = s;
        s_wrap[idx +: CHUNK] = sum_c;
        ovf_n   = c_msb ^ cout_c;
`ifdef SERIAL_ADDSUB_SAT_EN
        if (ovf_n)
            s_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            s_fin = s_wrap;
`else
        s_fin = s_wrap;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            cf        <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b ^ {WIDTH{sub}};
                        sub_q    <= sub;
                        carry    <= sub;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    carry <= cout_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        s         <= s_fin;
                        cout      <= cout_c;
                        cf        <= cout_c & ~sub_q;
                        ovf       <= ovf_n;
                        zero      <= (s_fin == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        s <= s_wrap;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
